// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ROR = 4'd9;
    localparam logic [3:0] OP_INC = 4'd10;
    localparam logic [3:0] OP_ADC = 4'd11;
    localparam logic [3:0] OP_SBC = 4'd12;

    localparam int NUM_OPS = 13;

    localparam int FLAG_C    = 0;
    localparam int FLAG_V    = 1;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_N    = 3;
    localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: one shared WIDTH+1 bit adder for all arithmetic ops.
// Latency: 0 cycles. Backpressure: none (pure function of its inputs).
// Subtraction is A + ~B + 1, so the adder carry-out is directly "no borrow".
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    input  logic             cin,
    output logic [WIDTH-1:0] res,
    output logic             c,
    output logic             v,
    output logic             bad
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]     amt;
    logic [WIDTH-1:0]   add_b;
    logic               add_c;
    logic [WIDTH:0]     sum_ext;
    logic               add_v;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic [2*WIDTH-1:0] rot_l;
    logic [2*WIDTH-1:0] rot_r;

    assign amt = b[SHW-1:0];

    always_comb begin
        add_b = b;
        add_c = 1'b0;
        case (sel)
            OP_SUB:  begin add_b = ~b;           add_c = 1'b1; end
            OP_INC:  begin add_b = '0;           add_c = 1'b1; end
            OP_ADC:  begin add_b = b;            add_c = cin;  end
            OP_SBC:  begin add_b = ~b;           add_c = cin;  end
            default: begin add_b = b;            add_c = 1'b0; end
        endcase
    end

    assign sum_ext = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_c};
    assign add_v   = (a[WIDTH-1] == add_b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);

    // Extra bit on the shift side catches the last bit shifted out (zero for amt=0).
    assign shl_ext = {1'b0, a} << amt;
    assign shr_ext = {a, 1'b0} >> amt;
    assign rot_l   = {a, a} << amt;
    assign rot_r   = {a, a} >> amt;

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        bad = 1'b0;
        case (sel)
            OP_ADD, OP_SUB, OP_INC, OP_ADC, OP_SBC: begin
                res = sum_ext[WIDTH-1:0];
                c   = sum_ext[WIDTH];
                v   = add_v;
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_SHL: begin
                res = shl_ext[WIDTH-1:0];
                c   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                res = shr_ext[WIDTH:1];
                c   = shr_ext[0];
            end
            OP_ROL: res = rot_l[2*WIDTH-1:WIDTH];
            OP_ROR: res = rot_r[WIDTH-1:0];
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes, chained carry and sticky overflow.
// Latency: 2 cycles from accept to out_valid; 1 beat/clk while out_ready is high.
// Backpressure: in_ready = !s1_valid | adv2 (combinational, no skid); outputs hold while stalled.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             zero_flag,
    output logic             negative_flag,
    output logic             bad_op,
    output logic             sticky_ovf,
    input  logic             clr_sticky
);

    logic                 s1_valid;
    logic [WIDTH-1:0]     s1_a;
    logic [WIDTH-1:0]     s1_b;
    logic [3:0]           s1_sel;
    logic                 s2_valid;
    logic [NUM_FLAGS-1:0] s2_flags;
    logic                 cq;
    logic                 adv2;
    logic                 s2_load;
    logic [WIDTH-1:0]     core_res;
    logic                 core_c;
    logic                 core_v;
    logic                 core_bad;

    assign adv2     = !s2_valid || out_ready;
    assign in_ready = !s1_valid || adv2;
    assign s2_load  = s1_valid && adv2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sel   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= A;
                s1_b   <= B;
                s1_sel <= select;
            end
        end
    end

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a   (s1_a),
        .b   (s1_b),
        .sel (s1_sel),
        .cin (cq),
        .res (core_res),
        .c   (core_c),
        .v   (core_v),
        .bad (core_bad)
    );

    // cq follows every stage-2 load so ADC/SBC see the carry of the beat just ahead of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            result   <= '0;
            s2_flags <= '0;
            bad_op   <= 1'b0;
            cq       <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result           <= core_res;
                s2_flags[FLAG_C] <= core_c;
                s2_flags[FLAG_V] <= core_v;
                s2_flags[FLAG_Z] <= (core_res == '0);
                s2_flags[FLAG_N] <= core_res[WIDTH-1];
                bad_op           <= core_bad;
                cq               <= core_c;
            end
        end
    end

    // A new overflow outranks a coincident clear so no overflow event is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
        end else if (s2_load && core_v) begin
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end

    assign out_valid     = s2_valid;
    assign carry_flag    = s2_flags[FLAG_C];
    assign overflow_flag = s2_flags[FLAG_V];
    assign zero_flag     = s2_flags[FLAG_Z];
    assign negative_flag = s2_flags[FLAG_N];

endmodule
